// File: rtl/mcc_pkg.sv
// mcc_pkg: shared states, instruction classes, opcode/funct constants and ALUOp codes.
package mcc_pkg;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK} state_e;
  typedef enum logic [2:0] {C_R, C_LW, C_SW, C_BEQ, C_ADDI, C_J, C_JR, C_ILL} iclass_e;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_ADDU = 4'b1010;
  localparam logic [3:0] ALU_SUBU = 4'b1011;
endpackage

// File: rtl/mcc_alu_decode.sv
// mcc_alu_decode: R-type funct to ALUOp plus legality flag.
module mcc_alu_decode
  import mcc_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [3:0] alu_op_o,
  output logic       legal_o
);
  always_comb begin
    alu_op_o = ALU_NONE;
    legal_o  = 1'b1;
    case (funct_i)
      FN_ADD:  alu_op_o = ALU_ADD;
      FN_ADDU: alu_op_o = ALU_ADDU;
      FN_SUB:  alu_op_o = ALU_SUB;
      FN_SUBU: alu_op_o = ALU_SUBU;
      FN_AND:  alu_op_o = ALU_AND;
      FN_OR:   alu_op_o = ALU_OR;
      FN_NOR:  alu_op_o = ALU_NOR;
      FN_SLT:  alu_op_o = ALU_SLT;
      FN_SLL:  alu_op_o = ALU_SLL;
      FN_SRL:  alu_op_o = ALU_SRL;
      FN_SRA:  alu_op_o = ALU_SRA;
      default: legal_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control FSM.
// Define MCC_MEM_WAIT_EN to stretch MEMORY until mem_ready.
module multicycle_control
  import mcc_pkg::*;
#(
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic               RegWrite,
  output logic               MemToReg,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               Branch,
  output logic               Jump,
  output logic               RegDst,
  output logic               ALUSrc,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               instr_done,
  output logic               illegal
);
  state_e     state_q, state_d;
  logic [5:0] opcode_q, funct_q, op_e, fn_e;
  logic       run_q, r_legal, mem_go;
  logic [3:0] r_alu_op, alu_op;
  iclass_e    cls;
  // DECODE classifies the live IR fields; later states use the latched copy.
  assign op_e = (state_q == S_DECODE) ? opcode : opcode_q;
  assign fn_e = (state_q == S_DECODE) ? funct : funct_q;
  mcc_alu_decode u_alu_decode (.funct_i(fn_e), .alu_op_o(r_alu_op), .legal_o(r_legal));
  assign cls = (op_e == OP_RTYPE) ? ((fn_e == FN_JR) ? C_JR : r_legal ? C_R : C_ILL) :
               (op_e == OP_LW)   ? C_LW   :
               (op_e == OP_SW)   ? C_SW   :
               (op_e == OP_BEQ)  ? C_BEQ  :
               (op_e == OP_ADDI) ? C_ADDI :
               (op_e == OP_J)    ? C_J    : C_ILL;
`ifdef MCC_MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_go = 1'b1;
`endif
  assign ALUOp = ALUOP_W'(alu_op);
  // run_q holds outputs low for the cycle after a reset edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      opcode_q <= '0;
      funct_q  <= '0;
      run_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (run_q && state_q == S_DECODE) begin
        opcode_q <= opcode;
        funct_q  <= funct;
      end
    end
  end
  always_comb begin
    state_d = S_FETCH;
    {RegWrite, MemToReg, MemRead, MemWrite, Branch, Jump, RegDst, ALUSrc} = '0;
    {IRWrite, PCWrite, instr_done, illegal} = '0;
    alu_op = ALU_NONE;
    if (run_q) begin
      case (state_q)
        S_FETCH: begin
          {IRWrite, PCWrite, MemRead} = 3'b111;
          state_d = S_DECODE;
        end
        S_DECODE: begin
          illegal = (cls == C_ILL);
          state_d = illegal ? S_FETCH : S_EXECUTE;
        end
        S_EXECUTE: begin
          ALUSrc     = cls inside {C_LW, C_SW, C_ADDI};
          alu_op     = ALUSrc ? ALU_ADD : (cls == C_BEQ) ? ALU_SUB : (cls == C_R) ? r_alu_op : ALU_NONE;
          Branch     = cls inside {C_BEQ, C_JR};
          Jump       = (cls == C_J);
          instr_done = Branch || Jump;
          state_d    = instr_done ? S_FETCH : (cls inside {C_LW, C_SW}) ? S_MEMORY : S_WRITEBACK;
        end
        S_MEMORY: begin
          MemRead    = (cls == C_LW);
          MemWrite   = (cls == C_SW);
          instr_done = MemWrite && mem_go;
          state_d    = !mem_go ? S_MEMORY : MemWrite ? S_FETCH : S_WRITEBACK;
        end
        S_WRITEBACK: begin
          RegWrite   = 1'b1;
          RegDst     = (cls == C_R);
          MemToReg   = (cls == C_LW);
          instr_done = 1'b1;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized instruction stream checked cycle-by-cycle against a per-class model.
module tb_multicycle_control;
  logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic RegWrite, MemToReg, MemRead, MemWrite, Branch, Jump, RegDst, ALUSrc;
  logic IRWrite, PCWrite, instr_done, illegal;
  logic [3:0] ALUOp;
  logic [15:0] obs;
  int n_run = 0, n_fail = 0;
  localparam logic [11:0] RW = 12'h800, MTR = 12'h400, MR = 12'h200, MW = 12'h100;
  localparam logic [11:0] BR = 12'h080, JP = 12'h040, RD = 12'h020, AS = 12'h010;
  localparam logic [11:0] IRW = 12'h008, PCW = 12'h004, DN = 12'h002, IL = 12'h001;
  typedef struct packed {logic [15:0] v; logic r;} step_t;
  multicycle_control #(.ALUOP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .RegWrite(RegWrite), .MemToReg(MemToReg), .MemRead(MemRead), .MemWrite(MemWrite),
    .Branch(Branch), .Jump(Jump), .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .instr_done(instr_done), .illegal(illegal)
  );
  always #5 clk = ~clk;
  assign obs = {RegWrite, MemToReg, MemRead, MemWrite, Branch, Jump, RegDst, ALUSrc,
                IRWrite, PCWrite, instr_done, illegal, ALUOp};
  function automatic int exp_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 1;
      6'b100001: return 10;
      6'b100010: return 2;
      6'b100011: return 11;
      6'b100100: return 3;
      6'b100101: return 4;
      6'b100111: return 5;
      6'b101010: return 6;
      6'b000000: return 7;
      6'b000010: return 8;
      6'b000011: return 9;
      default:   return -1;
    endcase
  endfunction
  // 0 R, 1 LW, 2 SW, 3 BEQ, 4 ADDI, 5 J, 6 JR, 7 illegal
  function automatic int cls_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: return (fn == 6'b001000) ? 6 : (exp_alu(fn) >= 0) ? 0 : 7;
      6'b100011: return 1;
      6'b101011: return 2;
      6'b000100: return 3;
      6'b001000: return 4;
      6'b000010: return 5;
      default:   return 7;
    endcase
  endfunction
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input int nwait, input int abort_at);
    step_t q[$];
    int c = cls_of(op, fn);
    int a = exp_alu(fn);
    logic [11:0] mf;
    q.push_back({IRW | PCW | MR, 4'd0, 1'($urandom)});
    q.push_back({(c == 7) ? IL : 12'h0, 4'd0, 1'($urandom)});
    if (c != 7) begin
      case (c)
        0:       q.push_back({12'h0, 4'(a), 1'($urandom)});
        3:       q.push_back({BR | DN, 4'd2, 1'($urandom)});
        5:       q.push_back({JP | DN, 4'd0, 1'($urandom)});
        6:       q.push_back({BR | DN, 4'd0, 1'($urandom)});
        default: q.push_back({AS, 4'd1, 1'($urandom)});
      endcase
      if (c == 1 || c == 2) begin
        mf = (c == 1) ? MR : MW;
`ifdef MCC_MEM_WAIT_EN
        repeat (nwait) q.push_back({mf, 4'd0, 1'b0});
        q.push_back({mf | ((c == 2) ? DN : 12'h0), 4'd0, 1'b1});
`else
        q.push_back({mf | ((c == 2) ? DN : 12'h0), 4'd0, 1'($urandom)});
`endif
      end
      if (c == 0 || c == 1 || c == 4)
        q.push_back({RW | DN | ((c == 0) ? RD : 12'h0) | ((c == 1) ? MTR : 12'h0), 4'd0, 1'($urandom)});
    end
    foreach (q[i]) begin
      @(posedge clk); #1;
      opcode = (i == 1) ? op : 6'($urandom);
      funct = (i == 1) ? fn : 6'($urandom);
      mem_ready = q[i].r;
      #1;
      n_run++;
      if (obs !== q[i].v) begin
        n_fail++;
        $display("FAIL %s op=%b fn=%b cycle %0d: got %h want %h", name, op, fn, i + 1, obs, q[i].v);
      end
      if (i == abort_at) begin
        rst_n = 1'b0;
        return;
      end
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      opcode = 6'($urandom);
      mem_ready = 1'($urandom);
      #1;
      n_run++;
      if (obs !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %h want 0000", obs);
      end
    end
    rst_n = 1'b1;
  endtask
  task automatic test_r_add();      run_instr("r_add", 6'b000000, 6'b100000, 0, -1); endtask
  task automatic test_lw();         run_instr("lw", 6'b100011, 6'($urandom), 2, -1); endtask
  task automatic test_beq();        run_instr("beq", 6'b000100, 6'($urandom), 0, -1); endtask
  task automatic test_illegal();    run_instr("illegal", 6'b111111, 6'b100000, 0, -1); endtask
  task automatic test_illegal_fn(); run_instr("illegal_funct", 6'b000000, 6'b111111, 0, -1); endtask
  task automatic test_sw_wait();    run_instr("sw_wait", 6'b101011, 6'($urandom), 3, -1); endtask
  task automatic test_reset_mid_lw();
    run_instr("lw_abort", 6'b100011, 6'($urandom), 2, 3);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    #1;
    n_run++;
    if (obs !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mid_lw: got %h want 0000", obs);
    end
    rst_n = 1'b1;
    run_instr("after_abort", 6'b000000, 6'b100010, 0, -1);
  endtask
  task automatic test_random();
    logic [5:0] ops [7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b000000};
    logic [5:0] fns [12] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
                             6'b100111, 6'b101010, 6'b000000, 6'b000010, 6'b000011, 6'b001000};
    logic [5:0] op, fn;
    for (int k = 0; k < 60; k++) begin
      op = ($urandom_range(0, 5) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 11)];
      run_instr("random", op, fn, int'($urandom_range(0, 3)), -1);
    end
  endtask
  initial begin
    test_reset();
    test_r_add();
    test_lw();
    test_beq();
    test_illegal();
    test_illegal_fn();
    test_sw_wait();
    test_reset_mid_lw();
    test_random();
    test_r_add();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", n_run);
    $fatal(1);
  end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter ALUOP_W, default 4: ALUOp width, minimum 4; codes zero-extended to ALUOP_W.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 opcode  input  6  instruction opcode field from external IR; sampled only in DECODE.
REQ-005 funct  input  6  R-type function field from external IR; sampled only in DECODE.
REQ-006 mem_ready  input  1  data-memory completion strobe; used only when MCC_MEM_WAIT_EN is defined.
REQ-007 RegWrite, MemToReg, MemRead, MemWrite, Branch, Jump, RegDst, ALUSrc  output  1 each  datapath controls, same meanings as the single-cycle decoder.
REQ-008 ALUOp  output  ALUOP_W  ALU operation code.
REQ-009 IRWrite, PCWrite  output  1 each  instruction-register load; PC+4 update.
REQ-010 instr_done  output  1  one-cycle pulse in the final state of each instruction.
REQ-011 illegal  output  1  one-cycle pulse on an unsupported opcode or funct.

Function
REQ-012 FSM states: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK; all outputs Moore-decoded from state plus latched opcode/funct.
REQ-013 FETCH: IRWrite=1, PCWrite=1, MemRead=1; all other outputs 0; next state DECODE.
REQ-014 DECODE: latch opcode/funct; classify as R, LW (100011), SW (101011), BEQ (000100), ADDI (001000), J (000010), JR (R-type funct 001000) or ILLEGAL.
REQ-015 R-type funct map: 100000 ADD, 100001 ADDU, 100010 SUB, 100011 SUBU, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT, 000000 SLL, 000010 SRL, 000011 SRA.
REQ-016 ILLEGAL: illegal=1 in DECODE; next state FETCH; RegWrite and MemWrite never asserted.
REQ-017 EXECUTE: R/JR use ALUSrc=0; LW/SW/ADDI use ALUSrc=1 with ALUOp=ADD; BEQ uses ALUOp=SUB with Branch=1; J asserts Jump=1; JR asserts Branch=1.
REQ-018 BEQ, J and JR end in EXECUTE (instr_done=1, next FETCH): 3 cycles total.
REQ-019 LW/SW proceed to MEMORY; MemRead=1 for LW, MemWrite=1 for SW; SW ends here (4 cycles).
REQ-020 R and ADDI proceed from EXECUTE to WRITEBACK; LW proceeds from MEMORY to WRITEBACK.
REQ-021 WRITEBACK: RegWrite=1; RegDst=1 for R, 0 for LW/ADDI; MemToReg=1 only for LW; instr_done=1; next FETCH.
REQ-022 Latency: R/ADDI 4 cycles, LW 5 cycles, SW 4 cycles, BEQ/J/JR 3 cycles, ILLEGAL 2 cycles.
REQ-023 opcode/funct changes outside DECODE have no effect on the current instruction.
REQ-024 instr_done and illegal are never asserted in the same cycle.

Reset
REQ-025 rst_n low at a rising edge: state=FETCH, latched fields cleared to 0; all outputs 0 in that cycle.
REQ-026 Reset mid-instruction abandons it: no further RegWrite/MemWrite, no instr_done; FETCH follows the first edge with rst_n high.

Configuration
REQ-027 MCC_MEM_WAIT_EN defined: MEMORY holds, with MemRead/MemWrite held high, until mem_ready=1; exit occurs on the edge where mem_ready=1.
REQ-028 MCC_MEM_WAIT_EN undefined: MEMORY lasts exactly one cycle; mem_ready is ignored.

Structure
REQ-029 Shared package mcc_pkg holds the state enum, opcode/funct constants, the instruction-class enum and 4-bit ALUOp codes: NONE 0000, ADD 0001, SUB 0010, AND 0011, OR 0100, NOR 0101, SLT 0110, SLL 0111, SRL 1000, SRA 1001, ADDU 1010, SUBU 1011.
REQ-030 One combinational sub-module, mcc_alu_decode, maps latched funct to ALUOp and an R-type legal flag.

Verification
REQ-031 Reset, then opcode=000000 funct=100000 -> F,D,E,WB; ALUOp=0001 in E; RegWrite=1, RegDst=1 and instr_done=1 in cycle 4.
REQ-032 opcode=100011 -> 5 cycles; MemRead=1 in MEMORY; MemToReg=1 and RegWrite=1 in WB.
REQ-033 opcode=000100 -> Branch=1, ALUOp=0010 and instr_done=1 in cycle 3; RegWrite stays 0 throughout.
REQ-034 opcode=111111 -> illegal=1 in cycle 2; FETCH in cycle 3; no RegWrite/MemWrite.
REQ-035 SW with MCC_MEM_WAIT_EN and mem_ready low for 3 cycles -> MemWrite high for 4 cycles; instr_done on the mem_ready cycle.
REQ-036 rst_n low during LW MEMORY -> all outputs 0; FETCH follows; no WB occurs.
